// File: rtl/sys_array_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sys_array_sequencer: streams one K-beat tile into NDP_unit, then   |
// | returns out_c over valid/ready. Optional watchdog: SEQ_TIMEOUT_EN. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sys_array_sequencer #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 1,
  parameter int MAX_K      = 16,
  parameter int TIMEOUT    = 1024,
  localparam int AW = SYS_HEIGHT * ARR_HEIGHT * WIDTH,
  localparam int BW = SYS_WIDTH * ARR_WIDTH * WIDTH,
  localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH,
  localparam int KA = $clog2(MAX_K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [KA-1:0] wr_addr,
  input  logic [AW-1:0] wr_a,
  input  logic [BW-1:0] wr_b,
  input  logic [KA:0]   k_len,
  input  logic          start,
  output logic          busy,
  output logic          arr_reset,
  output logic [AW-1:0] arr_in_a,
  output logic [BW-1:0] arr_in_b,
  output logic          arr_in_done_flag,
  input  logic          arr_calc_done_flag,
  input  logic [CW-1:0] arr_out_c,
  output logic [CW-1:0] res_c,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_RST = 3'd1,
    S_FEED     = 3'd2,
    S_WAIT     = 3'd3,
    S_OUT      = 3'd4
  } state_t;

  localparam logic [KA:0] KMAX = (KA+1)'(MAX_K);

  generate
    if (MAX_K < 2 || (MAX_K & (MAX_K - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("sys_array_sequencer: MAX_K must be a power of 2 >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  state_t        state, state_n;
  logic [AW-1:0] buf_a [MAX_K];
  logic [BW-1:0] buf_b [MAX_K];
  logic [KA:0]   k_reg, k_n;
  logic [KA:0]   idx, idx_n;       // index of the next beat to present
  logic [AW-1:0] a_n;
  logic [BW-1:0] b_n;
  logic [CW-1:0] c_n;
  logic          err_n;
  logic          start_ok;
  logic          timeout_hit;

  assign start_ok = start && (k_len != '0) && (k_len <= KMAX);

  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE || state == S_OUT)) begin
      buf_a[wr_addr] <= wr_a;
      buf_b[wr_addr] <= wr_b;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    k_n     = k_reg;
    idx_n   = idx;
    a_n     = arr_in_a;
    b_n     = arr_in_b;
    c_n     = res_c;
    err_n   = err_timeout;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_n = S_LOAD_RST;
          k_n     = k_len;
          idx_n   = '0;
          err_n   = 1'b0;
        end
      end
      S_LOAD_RST: begin
        state_n = S_FEED;
        a_n     = buf_a[0];
        b_n     = buf_b[0];
        idx_n   = (KA+1)'(1);
      end
      S_FEED: begin
        if (idx == k_reg) begin
          state_n = S_WAIT;
        end else begin
          a_n   = buf_a[idx[KA-1:0]];
          b_n   = buf_b[idx[KA-1:0]];
          idx_n = idx + (KA+1)'(1);
        end
      end
      S_WAIT: begin
        if (arr_calc_done_flag) begin
          c_n     = arr_out_c;
          state_n = S_OUT;
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_OUT: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Operand buses idle at zero whenever the array sits in reset
    if (state_n == S_IDLE) begin
      a_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      k_reg            <= '0;
      idx              <= '0;
      busy             <= 1'b0;
      arr_reset        <= 1'b1;
      arr_in_a         <= '0;
      arr_in_b         <= '0;
      arr_in_done_flag <= 1'b0;
      res_c            <= '0;
      res_valid        <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      state            <= state_n;
      k_reg            <= k_n;
      idx              <= idx_n;
      busy             <= (state_n != S_IDLE);
      arr_reset        <= (state_n == S_IDLE) || (state_n == S_LOAD_RST);
      arr_in_a         <= a_n;
      arr_in_b         <= b_n;
      arr_in_done_flag <= (state_n == S_WAIT);
      res_c            <= c_n;
      res_valid        <= (state_n == S_OUT);
      err_timeout      <= err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_array_sequencer.sv
`default_nettype none
// tb_sys_array_sequencer: scoreboard bench; a behavioural stand-in for NDP_unit
// accumulates integer products of the streamed beats and answers in_done_flag.
module tb_sys_array_sequencer;
  localparam int KA = 4;
  localparam int AW = 64;
  localparam int BW = 64;
  localparam int CW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [KA-1:0] wr_addr = '0;
  logic [AW-1:0] wr_a = '0;
  logic [BW-1:0] wr_b = '0;
  logic [KA:0]   k_len = '0;
  logic          start = 1'b0;
  logic          busy, arr_reset, arr_in_done_flag, res_valid, err_timeout;
  logic [AW-1:0] arr_in_a;
  logic [BW-1:0] arr_in_b;
  logic          arr_calc_done_flag = 1'b0;
  logic [CW-1:0] arr_out_c = '1;
  logic [CW-1:0] res_c;
  logic          res_ready = 1'b0;

  always #5 clk = ~clk;

  sys_array_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .k_len(k_len), .start(start), .busy(busy), .arr_reset(arr_reset),
    .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .arr_in_done_flag(arr_in_done_flag),
    .arr_calc_done_flag(arr_calc_done_flag), .arr_out_c(arr_out_c),
    .res_c(res_c), .res_valid(res_valid), .res_ready(res_ready), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } beat_t;

  int            errors = 0;
  int            checks = 0;
  bit            hang = 1'b0;
  beat_t         beat_q[$];
  logic [CW-1:0] res_q[$];

  // C = A(4x5) * B(5x4) with A[r][k] = 10r+k+1, B = identity rows 0..3 plus row 4 = {1,2,3,4}
  int exp_tbl[16] = '{6, 12, 18, 24, 26, 42, 58, 74, 46, 72, 98, 124, 66, 102, 138, 174};

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] col_a(input int k);
    logic [AW-1:0] v;
    for (int r = 0; r < 4; r++) v[r*16 +: 16] = 16'(10 * r + k + 1);
    return v;
  endfunction

  function automatic logic [BW-1:0] row_b(input int k);
    logic [BW-1:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = (k == c) ? 16'd1 : ((k == 4) ? 16'(c + 1) : 16'd0);
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_c();
    logic [CW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(exp_tbl[i]);
    return v;
  endfunction

  // Array stand-in: checks each beat against the scoreboard and answers after 3 WAIT cycles
  int acc[16];
  int wait_cyc = 0;
  always @(negedge clk) begin
    beat_t e;
    if (arr_reset) begin
      foreach (acc[i]) acc[i] = 0;
      wait_cyc = 0;
      arr_calc_done_flag = 1'b0;
      arr_out_c = '1;
    end else if (arr_in_done_flag) begin
      wait_cyc++;
      if (wait_cyc >= 3 && !hang) begin
        arr_calc_done_flag = 1'b1;
        for (int i = 0; i < 16; i++) arr_out_c[i*16 +: 16] = 16'(acc[i]);
      end
    end else begin
      arr_calc_done_flag = 1'b0;
      arr_out_c = '1;
      if (busy && !res_valid) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            acc[r*4 + c] += int'(arr_in_a[r*16 +: 16]) * int'(arr_in_b[c*16 +: 16]);
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected beat a=%h b=%h, none expected", arr_in_a, arr_in_b);
        end else begin
          e = beat_q.pop_front();
          chk("beat_a", arr_in_a, e.a);
          chk("beat_b", arr_in_b, e.b);
        end
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected result %h, none expected", res_c);
      end else begin
        chk("res_c", res_c, res_q.pop_front());
      end
    end
  end

  task automatic push_exp(input int nbeats, input bit with_res);
    beat_t bt;
    for (int j = 0; j < nbeats; j++) begin
      bt.a = col_a(j);
      bt.b = row_b(j);
      beat_q.push_back(bt);
    end
    if (with_res) res_q.push_back(exp_c());
  endtask

  task automatic issue_start(input int k, input int nbeats, input bit with_res);
    push_exp(nbeats, with_res);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 5'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!res_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", res_valid, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;
    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_arr_reset", arr_reset, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 2: load tile, last write coincides with start
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = KA'(j); wr_a = col_a(j); wr_b = row_b(j);
    end
    push_exp(5, 1'b1);
    @(posedge clk); #1;
    wr_addr = KA'(4); wr_a = col_a(4); wr_b = row_b(4);
    start = 1'b1; k_len = 5'd5;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("load_busy", busy, 1'b1);
    chk("load_arr_reset", arr_reset, 1'b1);
    @(negedge clk);
    chk("feed_arr_reset", arr_reset, 1'b0);
    n = 1;
    while (!arr_in_done_flag && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_done_latency", n, 6);
    wait_valid(50);
    repeat (3) begin
      @(negedge clk);
      chk("res_valid_held", res_valid, 1'b1);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    chk("post_res_valid", res_valid, 1'b0);
    chk("post_busy", busy, 1'b0);

    // 3: illegal k_len ignored
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      start = 1'b1;
      k_len = (t == 0) ? 5'd0 : 5'd17;
      repeat (3) begin
        @(negedge clk);
        chk("illegal_busy", busy, 1'b0);
        chk("illegal_arr_reset", arr_reset, 1'b1);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    // 4: start and writes during FEED are ignored
    res_ready = 1'b1;
    issue_start(5, 5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; k_len = 5'd5;
    wr_en = 1'b1; wr_addr = KA'(3); wr_a = '1; wr_b = '1;
    @(posedge clk); #1;
    wr_addr = KA'(4);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_valid(50);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy, 1'b0);

    // 5: reset while beat 2 of 5 is on the bus
    issue_start(5, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_arr_reset", arr_reset, 1'b1);
    chk("midrst_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 1'b0);
    chk("midrst_beats_done", beat_q.size(), 0);
    res_ready = 1'b1;
    issue_start(5, 5, 1'b1);
    wait_valid(50);
    @(posedge clk); #1;
    res_ready = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // 6: watchdog
    hang = 1'b1;
    issue_start(2, 2, 1'b0);
    n = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 40);
    chk("timeout_latency", n, 11);
    chk("timeout_err", err_timeout, 1'b1);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_arr_reset", arr_reset, 1'b1);
    hang = 1'b0;
    res_ready = 1'b1;
    issue_start(5, 5, 1'b1);
    @(negedge clk);
    chk("timeout_cleared", err_timeout, 1'b0);
    wait_valid(50);
    @(posedge clk); #1;
    res_ready = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "tb_sys_array_sequencer stalled");
  end

endmodule
`default_nettype wire
